// File: rtl/battleship_pkg.sv
// Shared types and defaults for the battleship game controller.
package battleship_pkg;

  localparam int MAX_SHIPS_DEF = 5;

  typedef enum logic [2:0] {
    DECISION    = 3'd0,
    PLACEMENT   = 3'd1,
    PC_SETUP    = 3'd2,
    PLAYER_TURN = 3'd3,
    PC_TURN     = 3'd4,
    VICTORY     = 3'd5,
    DEFEAT      = 3'd6
  } game_state_t;

endpackage

// File: rtl/battleship_game_ctrl_turn_timer.sv
// Player-turn countdown: load to TURN_CYCLES-1, count down while enabled, idle at 0.
module turn_timer #(
  parameter int unsigned TURN_CYCLES = 750_000_000,
  parameter int          TMR_W       = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  output logic [TMR_W-1:0] count,
  output logic             expired
);

  localparam logic [TMR_W-1:0] RELOAD = (TURN_CYCLES == 0) ? '0 : TMR_W'(TURN_CYCLES - 1);

  logic [TMR_W-1:0] r_count;

  // Anything other than load/enable parks the counter at 0 so it reads 0 outside a turn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_count <= '0;
    else if (load)             r_count <= RELOAD;
    else if (enable)           r_count <= (r_count == '0) ? '0 : r_count - TMR_W'(1);
    else                       r_count <= '0;
  end

  assign count   = r_count;
  assign expired = (TURN_CYCLES != 0) && (r_count == '0);

endmodule

// File: rtl/battleship_game_ctrl.sv
// Battleship game sequencer: ship-count decision, placement, alternating turns,
// per-turn timeout, round counting and restart from the end screens.
module battleship_game_ctrl
  import battleship_pkg::*;
#(
  parameter int          MAX_SHIPS   = MAX_SHIPS_DEF,
  parameter int          CNT_W       = 3,
  parameter int unsigned TURN_CYCLES = 750_000_000,
  parameter int          TMR_W       = 30,
  parameter int          ROUND_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   ship_sel,
  input  logic               ships_decided,
  input  logic               place_confirm,
  input  logic               pc_place_done,
  input  logic               player_shot,
  input  logic               player_sunk,
  input  logic               pc_shot,
  input  logic               pc_sunk,
  input  logic               new_game,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   ships_to_place,
  output logic [CNT_W-1:0]   player_ships_left,
  output logic [CNT_W-1:0]   pc_ships_left,
  output logic [TMR_W-1:0]   turn_timer,
  output logic               turn_timeout,
  output logic [ROUND_W-1:0] round_count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  game_state_t        r_state,   w_state_nxt;
  logic [CNT_W-1:0]   r_n,       w_n_nxt;
  logic [CNT_W-1:0]   r_to_place, w_to_place_nxt;
  logic [CNT_W-1:0]   r_pl_left, w_pl_left_nxt;
  logic [CNT_W-1:0]   r_pc_left, w_pc_left_nxt;
  logic [ROUND_W-1:0] r_round,   w_round_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               w_tmr_load, w_tmr_en, w_tmr_expired;
  logic [TMR_W-1:0]   w_tmr_count;
  logic               w_sel_ok;

  assign w_sel_ok = (ship_sel != '0) && (int'(ship_sel) <= MAX_SHIPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= DECISION;
      r_n        <= '0;
      r_to_place <= '0;
      r_pl_left  <= '0;
      r_pc_left  <= '0;
      r_round    <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_n        <= w_n_nxt;
      r_to_place <= w_to_place_nxt;
      r_pl_left  <= w_pl_left_nxt;
      r_pc_left  <= w_pc_left_nxt;
      r_round    <= w_round_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_n_nxt        = r_n;
    w_to_place_nxt = r_to_place;
    w_pl_left_nxt  = r_pl_left;
    w_pc_left_nxt  = r_pc_left;
    w_round_nxt    = r_round;
    w_timeout_nxt  = 1'b0;
    w_tmr_load     = 1'b0;
    case (r_state)
      DECISION: begin
        if (ships_decided && w_sel_ok) begin
          w_n_nxt        = ship_sel;
          w_to_place_nxt = ship_sel;
          w_pl_left_nxt  = ship_sel;
          w_pc_left_nxt  = ship_sel;
          w_round_nxt    = '0;
          w_state_nxt    = PLACEMENT;
        end
      end
      PLACEMENT: begin
        if (place_confirm) begin
          if (r_to_place <= ONE) begin
            w_to_place_nxt = r_n;
            w_state_nxt    = PC_SETUP;
          end else begin
            w_to_place_nxt = r_to_place - ONE;
          end
        end
      end
      PC_SETUP: begin
        if (pc_place_done) begin
          if (r_to_place <= ONE) begin
            w_to_place_nxt = '0;
            w_state_nxt    = PLAYER_TURN;
            w_tmr_load     = 1'b1;
          end else begin
            w_to_place_nxt = r_to_place - ONE;
          end
        end
      end
      PLAYER_TURN: begin
        // A resolved shot takes priority over a same-cycle expiry.
        if (player_shot) begin
          w_state_nxt = PC_TURN;
          if (player_sunk) begin
            w_pc_left_nxt = (r_pc_left == '0) ? '0 : r_pc_left - ONE;
            if (r_pc_left <= ONE) w_state_nxt = VICTORY;
          end
        end else if (w_tmr_expired) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = PC_TURN;
        end
      end
      PC_TURN: begin
        if (pc_shot) begin
          if (pc_sunk && (r_pl_left <= ONE)) begin
            w_pl_left_nxt = '0;
            w_state_nxt   = DEFEAT;
          end else begin
            if (pc_sunk) w_pl_left_nxt = r_pl_left - ONE;
            w_round_nxt = (r_round == '1) ? r_round : r_round + ROUND_W'(1);
            w_state_nxt = PLAYER_TURN;
            w_tmr_load  = 1'b1;
          end
        end
      end
      VICTORY, DEFEAT: begin
        if (new_game) begin
          w_n_nxt        = '0;
          w_to_place_nxt = '0;
          w_pl_left_nxt  = '0;
          w_pc_left_nxt  = '0;
          w_round_nxt    = '0;
          w_state_nxt    = DECISION;
        end
      end
      default: begin
        w_n_nxt        = '0;
        w_to_place_nxt = '0;
        w_pl_left_nxt  = '0;
        w_pc_left_nxt  = '0;
        w_round_nxt    = '0;
        w_state_nxt    = DECISION;
      end
    endcase
  end

  assign w_tmr_en = (r_state == PLAYER_TURN) && (w_state_nxt == PLAYER_TURN);

  turn_timer #(
    .TURN_CYCLES (TURN_CYCLES),
    .TMR_W       (TMR_W)
  ) u_turn_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (w_tmr_load),
    .enable  (w_tmr_en),
    .count   (w_tmr_count),
    .expired (w_tmr_expired)
  );

  assign state             = r_state;
  assign ships_to_place    = r_to_place;
  assign player_ships_left = r_pl_left;
  assign pc_ships_left     = r_pc_left;
  assign turn_timer        = w_tmr_count;
  assign turn_timeout      = r_timeout;
  assign round_count       = r_round;

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Scenario bench for battleship_game_ctrl with an expected-snapshot queue.
module tb_battleship_game_ctrl;
  import battleship_pkg::*;

  localparam logic [7:0] P_DEC = 8'h01, P_CONF = 8'h02, P_DONE = 8'h04, P_PSHOT = 8'h08,
                         P_PSUNK = 8'h10, P_CSHOT = 8'h20, P_CSUNK = 8'h40, P_NEW = 8'h80;

  typedef struct packed {
    logic [2:0]  st;
    logic [2:0]  tp;
    logic [2:0]  pl;
    logic [2:0]  pc;
    logic [29:0] tmr;
    logic        to;
    logic [7:0]  rnd;
  } snap_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic [2:0]  ship_sel = '0;
  logic        ships_decided = 0, place_confirm = 0, pc_place_done = 0, player_shot = 0;
  logic        player_sunk = 0, pc_shot = 0, pc_sunk = 0, new_game = 0;
  logic [2:0]  state, ships_to_place, player_ships_left, pc_ships_left;
  logic [29:0] turn_timer;
  logic        turn_timeout;
  logic [7:0]  round_count;

  snap_t e, got, want;
  snap_t q[$];
  int    n_run = 0, n_fail = 0;

  battleship_game_ctrl #(
    .MAX_SHIPS(5), .CNT_W(3), .TURN_CYCLES(8), .TMR_W(30), .ROUND_W(8)
  ) dut (
    .clk(clk), .rst(rst), .ship_sel(ship_sel), .ships_decided(ships_decided),
    .place_confirm(place_confirm), .pc_place_done(pc_place_done),
    .player_shot(player_shot), .player_sunk(player_sunk), .pc_shot(pc_shot),
    .pc_sunk(pc_sunk), .new_game(new_game), .state(state),
    .ships_to_place(ships_to_place), .player_ships_left(player_ships_left),
    .pc_ships_left(pc_ships_left), .turn_timer(turn_timer),
    .turn_timeout(turn_timeout), .round_count(round_count)
  );

  always #5 clk = ~clk;

  function automatic snap_t obs();
    return '{st: state, tp: ships_to_place, pl: player_ships_left, pc: pc_ships_left,
             tmr: turn_timer, to: turn_timeout, rnd: round_count};
  endfunction

  task automatic step(input logic [2:0] sel, input logic [7:0] p);
    ship_sel = sel;
    ships_decided = p[0]; place_confirm = p[1]; pc_place_done = p[2]; player_shot = p[3];
    player_sunk = p[4]; pc_shot = p[5]; pc_sunk = p[6]; new_game = p[7];
    @(posedge clk); #1;
    ships_decided = 0; place_confirm = 0; pc_place_done = 0; player_shot = 0;
    player_sunk = 0; pc_shot = 0; pc_sunk = 0; new_game = 0;
  endtask

  task automatic test_reset();
    ship_sel = 3'd3; ships_decided = 1;
    repeat (2) @(posedge clk);
    #1;
    ships_decided = 0;
    e = '0;
    q.push_back(e);
    got = obs(); want = q.pop_front(); n_run++;
    if (got !== want) begin n_fail++; $display("FAIL reset: got %h want %h", got, want); end
    rst = 0;
  endtask

  task automatic test_decision();
    logic [2:0] sels [4];
    sels = '{3'd0, 3'd6, 3'd7, 3'd3};
    for (int i = 0; i < 4; i++) begin
      if (sels[i] == 3'd3) begin e.st = PLACEMENT; e.tp = 3; e.pl = 3; e.pc = 3; end
      q.push_back(e);
      step(sels[i], (i == 0) ? (P_DEC | P_CONF | P_NEW) : P_DEC);
      got = obs(); want = q.pop_front(); n_run++;
      if (got !== want) begin n_fail++; $display("FAIL decision[%0d]: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_placement();
    logic [7:0] seq [7];
    seq = '{P_DONE, P_CONF, P_CONF, P_CONF, P_DONE, P_DONE, P_DONE};
    for (int i = 0; i < 7; i++) begin
      case (i)
        1: e.tp = 2;
        2: e.tp = 1;
        3: begin e.st = PC_SETUP; e.tp = 3; end
        4: e.tp = 2;
        5: e.tp = 1;
        6: begin e.st = PLAYER_TURN; e.tp = 0; e.tmr = 7; end
        default: ;
      endcase
      q.push_back(e);
      step(3'd3, seq[i]);
      got = obs(); want = q.pop_front(); n_run++;
      if (got !== want) begin n_fail++; $display("FAIL placement[%0d]: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_timeout();
    for (int k = 1; k <= 9; k++) begin
      if (k <= 7) e.tmr = 30'(7 - k);
      if (k == 8) begin e.st = PC_TURN; e.tmr = 0; e.to = 1; end
      if (k == 9) e.to = 0;
      q.push_back(e);
      step(3'd0, 8'h00);
      got = obs(); want = q.pop_front(); n_run++;
      if (got !== want) begin n_fail++; $display("FAIL timeout_idle[%0d]: got %h want %h", k, got, want); end
    end
    for (int k = 0; k <= 9; k++) begin
      if (k == 0) begin e.rnd = 1; e.st = PLAYER_TURN; e.tmr = 7; end
      else if (k <= 7) e.tmr = 30'(7 - k);
      else if (k == 8) begin e.st = PC_TURN; e.tmr = 0; end
      q.push_back(e);
      step(3'd0, (k == 0) ? P_CSHOT : (k == 8) ? P_PSHOT : 8'h00);
      got = obs(); want = q.pop_front(); n_run++;
      if (got !== want) begin n_fail++; $display("FAIL timeout_shot[%0d]: got %h want %h", k, got, want); end
    end
    e.rnd = 2; e.st = PLAYER_TURN; e.tmr = 7;
    q.push_back(e);
    step(3'd0, P_CSHOT);
    got = obs(); want = q.pop_front(); n_run++;
    if (got !== want) begin n_fail++; $display("FAIL timeout_resume: got %h want %h", got, want); end
  endtask

  task automatic test_defeat();
    logic [7:0] seq [10];
    seq = '{P_PSHOT, P_CSHOT | P_CSUNK, P_PSHOT, P_CSHOT | P_CSUNK, P_PSHOT, P_CSHOT | P_CSUNK,
            P_PSHOT | P_PSUNK, P_CSHOT | P_CSUNK, P_DEC | P_CONF | P_DONE, P_NEW};
    for (int i = 0; i < 10; i++) begin
      case (i)
        0, 2, 4: begin e.st = PC_TURN; e.tmr = 0; end
        1: begin e.pl = 2; e.rnd = 3; e.st = PLAYER_TURN; e.tmr = 7; end
        3: begin e.pl = 1; e.rnd = 4; e.st = PLAYER_TURN; e.tmr = 7; end
        5: begin e.pl = 0; e.st = DEFEAT; end
        9: e = '0;
        default: ;
      endcase
      q.push_back(e);
      step(3'd2, seq[i]);
      got = obs(); want = q.pop_front(); n_run++;
      if (got !== want) begin n_fail++; $display("FAIL defeat[%0d]: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_victory();
    logic [7:0] seq [11];
    seq = '{P_DEC, P_CONF, P_CONF, P_DONE, P_DONE, P_PSHOT | P_PSUNK, P_CSHOT, P_NEW,
            P_PSHOT | P_PSUNK, P_CSHOT | P_CSUNK, P_NEW};
    for (int i = 0; i < 11; i++) begin
      case (i)
        0: begin e.st = PLACEMENT; e.tp = 2; e.pl = 2; e.pc = 2; e.rnd = 0; end
        1: e.tp = 1;
        2: begin e.st = PC_SETUP; e.tp = 2; end
        3: e.tp = 1;
        4: begin e.st = PLAYER_TURN; e.tp = 0; e.tmr = 7; end
        5: begin e.pc = 1; e.st = PC_TURN; e.tmr = 0; end
        6: begin e.rnd = 1; e.st = PLAYER_TURN; e.tmr = 7; end
        7: e.tmr = 6;
        8: begin e.pc = 0; e.st = VICTORY; e.tmr = 0; end
        10: e = '0;
        default: ;
      endcase
      q.push_back(e);
      step(3'd2, seq[i]);
      got = obs(); want = q.pop_front(); n_run++;
      if (got !== want) begin n_fail++; $display("FAIL victory[%0d]: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] seq [6];
    seq = '{P_DEC, P_CONF, P_DONE, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin e.st = PLACEMENT; e.tp = 1; e.pl = 1; e.pc = 1; end
        1: e.st = PC_SETUP;
        2: begin e.st = PLAYER_TURN; e.tp = 0; e.tmr = 7; end
        default: e.tmr = 30'(9 - i);
      endcase
      q.push_back(e);
      step(3'd1, seq[i]);
      got = obs(); want = q.pop_front(); n_run++;
      if (got !== want) begin n_fail++; $display("FAIL midrst_setup[%0d]: got %h want %h", i, got, want); end
    end
    #2 rst = 1;
    #1;
    e = '0;
    q.push_back(e);
    got = obs(); want = q.pop_front(); n_run++;
    if (got !== want) begin n_fail++; $display("FAIL midrst_async: got %h want %h", got, want); end
    q.push_back(e);
    step(3'd5, P_DEC);
    got = obs(); want = q.pop_front(); n_run++;
    if (got !== want) begin n_fail++; $display("FAIL midrst_held: got %h want %h", got, want); end
    rst = 0;
    e.st = PLACEMENT; e.tp = 5; e.pl = 5; e.pc = 5;
    q.push_back(e);
    step(3'd5, P_DEC);
    got = obs(); want = q.pop_front(); n_run++;
    if (got !== want) begin n_fail++; $display("FAIL midrst_restart: got %h want %h", got, want); end
  endtask

  initial begin
    test_reset();
    test_decision();
    test_placement();
    test_timeout();
    test_defeat();
    test_victory();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests run %0d", n_run);
    $fatal(1);
  end

endmodule
